// File: rtl/icache_pkg.sv
// Shared sizing, address-split struct and FSM state type for the direct-mapped
// instruction cache.
package icache_pkg;

  localparam int ADDR_W         = 32;
  localparam int NUM_LINES      = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W       = $clog2(WORDS_PER_LINE);
  localparam int INDEX_W        = $clog2(NUM_LINES);
  localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W - 2;

  typedef enum logic {IDLE, REFILL} icache_state_t;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [1:0]          byte_sel;
  } icache_addr_t;

  function automatic icache_addr_t split_addr(input logic [ADDR_W-1:0] addr);
    return icache_addr_t'(addr);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage: combinational read port, one write port,
// and a synchronous clear of every valid bit.
module icache_array
  import icache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_all,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [31:0]         rd_data,
  input  logic                we,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_word,
  input  logic [31:0]         wr_data,
  input  logic                tag_we,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic                set_valid
);

  logic [31:0]          data_mem [NUM_LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;

  // A tag write always decides the line's valid bit, so a flushed refill
  // lands with its new tag but stays invalid.
  always_comb begin
    valid_d = valid_q;
    if (clear_all) valid_d = '0;
    if (tag_we) valid_d[wr_index] = set_valid;
    if (!rst) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    if (we) data_mem[{wr_index, wr_word}] <= wr_data;
    if (tag_we) tag_mem[wr_index] <= wr_tag;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, stalling
// word-by-word line refill from a multi-cycle backing memory.
module instr_cache
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr,
  output logic              stall,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid
);

  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(WORDS_PER_LINE - 1);

  icache_state_t       state_q, state_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0]   refill_addr_q, refill_addr_d;
  logic                flush_pending_q, flush_pending_d;

  icache_addr_t        pc_f, refill_f;
  logic                rd_valid, hit;
  logic [TAG_W-1:0]    rd_tag;
  logic [31:0]         rd_data;
  logic                arr_we, tag_we, set_valid;
  logic                unused_addr_bits;

  assign pc_f     = split_addr(pc);
  assign refill_f = split_addr(refill_addr_q);
  assign hit      = rd_valid && (rd_tag == pc_f.tag);
  assign unused_addr_bits = ^{pc_f.byte_sel, refill_f.offset, refill_f.byte_sel};

  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    refill_addr_d   = refill_addr_q;
    flush_pending_d = flush_pending_q;
    stall           = 1'b0;
    instr           = '0;
    arr_we          = 1'b0;
    tag_we          = 1'b0;
    set_valid       = 1'b0;
    case (state_q)
      IDLE: begin
        flush_pending_d = 1'b0;
        if (hit) begin
          instr = rd_data;
        end else begin
          stall         = 1'b1;
          state_d       = REFILL;
          beat_d        = '0;
          refill_addr_d = {pc[ADDR_W-1:OFFSET_W+2], {(OFFSET_W+2){1'b0}}};
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (flush) flush_pending_d = 1'b1;
        if (mem_rvalid) begin
          arr_we = 1'b1;
          beat_d = beat_q + OFFSET_W'(1);
          if (beat_q == LAST_BEAT) begin
            tag_we          = 1'b1;
            set_valid       = !(flush_pending_q || flush);
            state_d         = IDLE;
            beat_d          = '0;
            flush_pending_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // While held in reset the fetch port idles and no beat may land.
    if (!rst) begin
      stall  = 1'b0;
      instr  = '0;
      arr_we = 1'b0;
      tag_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      beat_q          <= '0;
      refill_addr_q   <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      refill_addr_q   <= refill_addr_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign mem_req  = (state_q == REFILL);
  assign mem_addr = refill_addr_q;

  icache_array u_array (
    .clk       (clk),
    .rst       (rst),
    .clear_all (flush),
    .rd_index  (pc_f.index),
    .rd_offset (pc_f.offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .we        (arr_we),
    .wr_index  (refill_f.index),
    .wr_word   (beat_q),
    .wr_data   (mem_rdata),
    .tag_we    (tag_we),
    .wr_tag    (refill_f.tag),
    .set_valid (set_valid)
  );

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios followed by random
// fetches, checked against a line-level model of a direct-mapped cache.
module tb_instr_cache;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  int n_checks = 0;
  int n_err    = 0;

  // Model: which line address each index currently holds, and whether valid.
  bit          ref_ok   [16];
  logic [31:0] ref_line [16];
  logic [31:0] bmem [logic [31:0]];
  bit          last_miss;
  int          beat_gap [4] = '{0, 2, 0, 1};

  instr_cache dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instr      (instr),
    .stall      (stall),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) ref_ok[i] = 1'b0;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return ref_ok[a[7:4]] && (ref_line[a[7:4]] == {a[31:4], 4'b0});
  endfunction

  // One fetch to completion. gmode: 0 back-to-back beats, 1 random gaps,
  // 2 fixed gap table. flush_beat: beat index presented with flush (-1 none).
  task automatic fetch(input logic [31:0] a, input int gmode, input int flush_beat);
    logic [31:0] line;
    int          idx;
    int          gaps;
    bit          hit;
    bit          fl;
    line = {a[31:4], 4'b0};
    idx  = int'(a[7:4]);
    pc   = a;
    #1;
    hit = model_hit(a);
    chk1("lookup_stall", stall, !hit);
    $display("fetch pc=%h %s", a, hit ? "hit" : "miss");
    if (hit) begin
      last_miss = 1'b0;
      chk32("hit_instr", instr, mem_word({a[31:2], 2'b00}));
      chk1("hit_no_req", mem_req, 1'b0);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      step();
      mem_rvalid = 1'b0;
      return;
    end
    last_miss = 1'b1;
    step();
    chk1("refill_req", mem_req, 1'b1);
    chk32("refill_addr", mem_addr, line);
    chk1("refill_stall", stall, 1'b1);
    fl = 1'b0;
    for (int b = 0; b < 4; b++) begin
      gaps = (gmode == 1) ? int'($urandom_range(0, 2)) : (gmode == 2) ? beat_gap[b] : 0;
      for (int g = 0; g < gaps; g++) begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        step();
        chk1("gap_req", mem_req, 1'b1);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(line + 32'(4 * b));
      if (b == flush_beat) begin
        flush = 1'b1;
        fl    = 1'b1;
        model_clear();
      end
      step();
      flush      = 1'b0;
      mem_rvalid = 1'b0;
      if (b < 3) chk1("beat_req", mem_req, 1'b1);
    end
    ref_line[idx] = line;
    ref_ok[idx]   = !fl;
    chk1("req_drop", mem_req, 1'b0);
    chk1("post_stall", stall, fl);
    if (!fl) chk32("post_instr", instr, mem_word({a[31:2], 2'b00}));
  endtask

  // Flush pulse on a cycle whose lookup hits; that lookup sees old valids.
  task automatic idle_flush(input logic [31:0] a);
    pc = a;
    #1;
    chk1("flush_cycle_stall", stall, 1'b0);
    chk32("flush_cycle_instr", instr, mem_word({a[31:2], 2'b00}));
    $display("flush in idle pc=%h", a);
    flush = 1'b1;
    step();
    flush = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [31:0] a;
    int          fb;
    rst        = 1'b0;
    pc         = '0;
    flush      = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    model_clear();
    for (int i = 0; i < 16; i++) ref_line[i] = '0;
    bmem[32'h00] = 32'h11; bmem[32'h04] = 32'h22;
    bmem[32'h08] = 32'h33; bmem[32'h0C] = 32'h44;
    bmem[32'h40] = 32'hAAAA_0001; bmem[32'h44] = 32'hBBBB_0002;
    bmem[32'h48] = 32'hCCCC_0003; bmem[32'h4C] = 32'hDDDD_0004;

    step();
    step();
    chk1("rst_stall", stall, 1'b0);
    chk32("rst_instr", instr, 32'h0);
    chk1("rst_req", mem_req, 1'b0);
    chk32("rst_addr", mem_addr, 32'h0);
    $display("reset checked");
    rst = 1'b1;

    // Cold miss then hits on the same line
    fetch(32'h00, 0, -1);
    chk1("cold_was_miss", last_miss, 1'b1);
    fetch(32'h04, 0, -1);
    fetch(32'h08, 0, -1);
    fetch(32'h0C, 0, -1);
    chk1("line0_was_hit", last_miss, 1'b0);

    // Conflict eviction of line 0
    fetch(32'h100, 0, -1);
    chk1("conflict_miss", last_miss, 1'b1);
    fetch(32'h000, 0, -1);
    chk1("evicted_miss", last_miss, 1'b1);

    // Gapped beats 1,0,0,1,1,0,1
    fetch(32'h40, 2, -1);
    fetch(32'h44, 0, -1);
    fetch(32'h48, 0, -1);
    fetch(32'h4C, 0, -1);
    chk1("gapped_line_hit", last_miss, 1'b0);

    // Reset after two beats of a refill
    pc = 32'h50;
    #1;
    chk1("rstmid_miss", stall, 1'b1);
    step();
    chk1("rstmid_req", mem_req, 1'b1);
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(32'h50 + 32'(4 * b));
      step();
    end
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    step();
    chk1("rstmid_req_drop", mem_req, 1'b0);
    chk1("rstmid_stall", stall, 1'b0);
    chk32("rstmid_instr", instr, 32'h0);
    step();
    chk1("rstmid_req_held", mem_req, 1'b0);
    $display("reset mid-refill checked");
    rst        = 1'b1;
    mem_rvalid = 1'b0;
    model_clear();
    fetch(32'h00, 0, -1);
    chk1("after_rst_miss", last_miss, 1'b1);

    // Flush in IDLE with lines 0 and 1 valid
    fetch(32'h10, 0, -1);
    idle_flush(32'h00);
    pc = 32'h00;
    #1;
    chk1("flushed_line0_miss", stall, 1'b1);
    pc = 32'h10;
    #1;
    chk1("flushed_line1_miss", stall, 1'b1);
    fetch(32'h10, 0, -1);

    // Flush during refill, and flush on the last beat
    fetch(32'h20, 0, 2);
    fetch(32'h20, 0, -1);
    chk1("flush_refill_remiss", last_miss, 1'b1);
    fetch(32'h30, 1, 3);
    fetch(32'h30, 0, -1);
    chk1("flush_last_remiss", last_miss, 1'b1);

    // Random fetches over four conflicting pages
    for (int i = 0; i < 150; i++) begin
      a = {22'b0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 2'b00};
      if (model_hit(a) && $urandom_range(0, 15) == 0) begin
        idle_flush(a);
      end else begin
        fb = int'($urandom_range(0, 23));
        if (fb > 3) fb = -1;
        fetch(a, 1, fb);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
